// File: rtl/operand_capture.sv
// Input stage: synchronises switches and load button, debounces the button and
// captures op/operand once per clean press. Define OPERAND_CAPTURE_LOADCNT_EN to add the load_cnt counter.
module operand_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw_op,
    input  logic [7:0] sw_num,
    input  logic       btn_load,
    output logic [2:0] op_q,
    output logic [7:0] num_q,
    output logic       load_pulse,
`ifdef OPERAND_CAPTURE_LOADCNT_EN
    output logic [7:0] load_cnt,
`endif
    output logic       busy
);

    localparam int SYNC_W = 12;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_W-1:0] raw_bus;
    logic [SYNC_W-1:0] meta_reg;
    logic [SYNC_W-1:0] sync_reg;
    logic              btn_s;
    logic [7:0]        sw_num_s;
    logic [2:0]        sw_op_s;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;

    assign raw_bus = {btn_load, sw_num, sw_op};

    // Two-flop synchroniser per raw input bit.
    generate
        for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= raw_bus[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign {btn_s, sw_num_s, sw_op_s} = sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_q       <= 3'b000;
            num_q      <= 8'h00;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= PRESS_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg  <= HELD;
                        op_q       <= sw_op_s;
                        num_q      <= sw_num_s;
                        load_pulse <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                HELD: begin
                    // No auto-repeat: only a qualified release re-arms the capture.
                    if (!btn_s) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_reg <= HELD;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign busy = (state_reg == PRESS_WAIT) || (state_reg == RELEASE_WAIT);

`ifdef OPERAND_CAPTURE_LOADCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt <= 8'h00;
        end else if (state_reg == PRESS_WAIT && btn_s && cnt_reg == CNT_LAST) begin
            load_cnt <= load_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: doc/operand_capture.md
# operand_capture

Upstream input stage for the ALU/display datapath. Synchronises the board's operation and operand switches and a debounced "load" push-button, then presents a stable registered operation code and 8-bit operand to the ALU, changing only on a clean button press. Removes switch metastability and contact bounce so the ALU result and the 7-segment display update once per deliberate press.

## Interface
- DEBOUNCE_CYCLES, 1000000: clock cycles the button must hold a level before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw_op  input  3  raw operation-select switches (asynchronous).
- sw_num  input  8  raw operand switches (asynchronous).
- btn_load  input  1  raw load push-button, active-high, bouncy.
- op_q  output  3  registered operation code feeding the ALU `op` input.
- num_q  output  8  registered operand feeding the ALU `num1` input.
- load_pulse  output  1  one-cycle strobe marking an op_q/num_q update.
- busy  output  1  high while a press or release is being qualified (PRESS_WAIT or RELEASE_WAIT).
- load_cnt  output  8  count of accepted loads (present only with the macro below).

## Operation
- Synchronisers: sw_op, sw_num, btn_load each pass through two flip-flops; internal signals sw_op_s, sw_num_s, btn_s. Synchroniser flops reset to 0.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: btn_s=1 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT: btn_s=0 → IDLE, cnt←0 (bounce rejected). Else if cnt=DEBOUNCE_CYCLES−1 → HELD, op_q←sw_op_s, num_q←sw_num_s, load_pulse←1. Else cnt←cnt+1.
  - HELD: btn_s=0 → RELEASE_WAIT, cnt←0. No further loads while held (no auto-repeat).
  - RELEASE_WAIT: btn_s=1 → HELD, cnt←0 (release bounce, no new load). Else if cnt=DEBOUNCE_CYCLES−1 → IDLE. Else cnt←cnt+1.
- Only the HELD-entry transition writes op_q/num_q; switch changes at any other time have no effect on outputs.
- load_pulse is registered, high for exactly one cycle (the cycle after HELD entry edge), otherwise 0.
- Reset values: state IDLE, cnt 0, op_q 3'b000, num_q 8'h00, load_pulse 0, busy 0, load_cnt 8'h00.
- Reset asserted mid-qualification or mid-hold aborts immediately; after release the FSM needs a fresh full press, even if btn_load is still high (it then re-qualifies from IDLE and loads once).

## Timing
- btn_load sampled high first at edge N and held: btn_s high after edge N+1, PRESS_WAIT after N+2, HELD entry and new op_q/num_q/load_pulse after edge N+DEBOUNCE_CYCLES+2; load_pulse low again after the next edge.
- Any low sample of btn_s during PRESS_WAIT restarts qualification; total latency then counts from the last rising sample.
- Latched values are the synchronised switch levels present at the HELD-entry edge (switch edges reach sw_*_s 2 cycles later).
- Minimum press-to-press period: 2·DEBOUNCE_CYCLES + 4 cycles.
- busy combinational from state; no other combinational input-to-output paths.

## Configuration
- OPERAND_CAPTURE_LOADCNT_EN defined: load_cnt port exists; 8-bit counter increments on every load_pulse, wraps 8'hFF→8'h00, reset to 0.
- Undefined: load_cnt port and counter are absent; all other behaviour identical.

## Test plan
(Simulated with DEBOUNCE_CYCLES=8, CNT_W=4.)
- Reset: assert reset with sw_num=8'hA5, btn_load=1 mid-cycle → op_q=0, num_q=0, load_pulse=0, busy=0 immediately (asynchronous); after release exactly one load of 8'hA5 occurs 10 edges later.
- Clean press: sw_op=3'b101, sw_num=8'h3C, btn_load high from edge N → load_pulse high for one cycle after edge N+10, op_q=5, num_q=8'h3C; no second pulse while held 100 cycles.
- Bounce: btn_load toggles 1,0,1,0 every 3 cycles then stays high → single load_pulse exactly 10 edges after the final rising sample.
- Release bounce: after HELD, btn_load drops for 3 cycles then high again → no load_pulse, state returns HELD, busy high only during the drop window.
- Switch isolation: change sw_num 8'h3C→8'hFF while HELD and in IDLE → num_q stays 8'h3C until next accepted press, then 8'hFF.
- With OPERAND_CAPTURE_LOADCNT_EN: 257 accepted presses → load_cnt=8'h01 (wrap verified at 256).
